// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetcher with a small FIFO ahead of IF.
// Define FETCH_BYPASS_EN to forward an acked word straight to IF when empty.
module inst_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_flag_id,
  input  logic [31:0] jump_address_id,
  input  logic        if_ready,
  output logic [31:0] instruction_read_data,
  output logic        instruction_valid,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0]   NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   hold_addr_q;
  logic [31:0]   fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   jump_target;
  logic          ack_ok;
  logic          byp;
  logic          push;
  logic          pop_fifo;

  assign jump_target = jump_address_id & 32'hFFFF_FFFC;
  assign ack_ok = (state_q == REQ) && mem_ack
               && !jump_flag_id;

`ifdef FETCH_BYPASS_EN
  assign byp = ack_ok && (count_q == '0);
`else
  assign byp = 1'b0;
`endif

  // A bypassed word taken by IF this cycle never enters the FIFO
  assign push     = ack_ok && !(byp && if_ready);
  assign pop_fifo = (count_q != '0) && if_ready
                 && !jump_flag_id;
  assign count_d  = count_q + CW'(push)
                  - CW'(pop_fifo);

  always_comb begin
    instruction_valid     = count_q != '0;
    instruction_read_data = NOP;
    if (count_q != '0)
      instruction_read_data = fifo_q[rd_ptr_q];
    if (byp) begin
      instruction_valid     = 1'b1;
      instruction_read_data = mem_rdata;
    end
  end

  assign mem_req  = state_q != IDLE;
  assign mem_addr = (state_q == DISCARD)
                  ? hold_addr_q : fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      IDLE: begin
        if (!jump_flag_id && count_q < FULL)
          state_d = REQ;
      end
      REQ: begin
        if (jump_flag_id) begin
          state_d = mem_ack ? IDLE : DISCARD;
        end else if (mem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d = (count_d < FULL) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (mem_ack)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (jump_flag_id)
      fetch_pc_d = jump_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      hold_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      // Old address stays on the bus while its data is dropped
      if (state_q == REQ && jump_flag_id && !mem_ack)
        hold_addr_q <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++)
        fifo_q[i] <= NOP;
    end else if (jump_flag_id) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_fifo)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Bench for inst_prefetch_buffer: latency-configurable memory responder
// and a program-order stream model of what IF must observe.
module tb_inst_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        jump_flag_id;
  logic [31:0] jump_address_id;
  logic        if_ready;
  logic [31:0] instruction_read_data;
  logic        instruction_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  inst_prefetch_buffer #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .jump_flag_id(jump_flag_id),
    .jump_address_id(jump_address_id),
    .if_ready(if_ready),
    .instruction_read_data(instruction_read_data),
    .instruction_valid(instruction_valid),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int          wmin, wmax, wcur, wcnt;
  bit          busy;
  logic [31:0] held;
  int          proto_err;
  logic [31:0] mdl_pc;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] issue_q[$];
  logic [31:0] alog[$];
  bit          vlog[$];
  bit          rlog[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a ^ 32'h1357_9BDF) * 32'h9E37_79B1;
  endfunction

  // One clock: drive inputs at negedge, act as memory, record IF stream
  task automatic tick(input logic rdy, input logic jmp,
                      input logic [31:0] ja);
    @(negedge clk);
    if_ready        = rdy;
    jump_flag_id    = jmp;
    jump_address_id = ja;
    mem_ack         = 1'b0;
    mem_rdata       = 32'hDEAD_BEEF;
    if (mem_req) begin
      if (mem_addr[1:0] != 2'b00) proto_err++;
      if (busy && mem_addr !== held) proto_err++;
      if (!busy) begin
        busy = 1'b1;
        held = mem_addr;
        wcnt = 0;
        wcur = int'($urandom_range(wmax, wmin));
        issue_q.push_back(mem_addr);
      end
      if (wcnt >= wcur) begin
        mem_ack   = 1'b1;
        mem_rdata = word_of(mem_addr);
        busy      = 1'b0;
      end else begin
        wcnt++;
      end
    end else if (busy) begin
      proto_err++;
      busy = 1'b0;
    end
    #1;
    vlog.push_back(instruction_valid);
    rlog.push_back(mem_req);
    alog.push_back(mem_addr);
    if (jmp) begin
      mdl_pc = ja & 32'hFFFF_FFFC;
    end else if (instruction_valid && rdy) begin
      got_q.push_back(instruction_read_data);
      exp_q.push_back(word_of(mdl_pc));
      mdl_pc = mdl_pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    if_ready        = 1'b0;
    jump_flag_id    = 1'b0;
    jump_address_id = '0;
    mem_ack         = 1'b0;
    mem_rdata       = '0;
    busy            = 1'b0;
    proto_err       = 0;
    mdl_pc          = RESET_PC;
    got_q.delete(); exp_q.delete(); issue_q.delete();
    alog.delete(); vlog.delete(); rlog.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wmin = 0; wmax = 0;
    if_ready = 1'b0; jump_flag_id = 1'b0;
    jump_address_id = '0; mem_ack = 1'b0; mem_rdata = '0;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0)
      $display("FAIL reset_req got=%b want=0", mem_req);
    else n_pass++;
    n_checks++;
    if (instruction_valid !== 1'b0)
      $display("FAIL reset_valid got=%b want=0", instruction_valid);
    else n_pass++;
    n_checks++;
    if (mem_addr !== RESET_PC)
      $display("FAIL reset_addr got=%h want=%h", mem_addr, RESET_PC);
    else n_pass++;
    n_checks++;
    if (instruction_read_data !== NOP)
      $display("FAIL reset_data got=%h want=%h",
               instruction_read_data, NOP);
    else n_pass++;
    do_reset();
    #1;
    n_checks++;
    if (mem_req !== 1'b0)
      $display("FAIL release_req got=%b want=0", mem_req);
    else n_pass++;
    tick(1'b0, 1'b0, '0);
    n_checks++;
    if (rlog[0] !== 1'b1)
      $display("FAIL first_req got=%b want=1", rlog[0]);
    else n_pass++;
  endtask

  task automatic test_zero_wait();
    int first_v;
    int nv;
    wmin = 0; wmax = 0;
    do_reset();
    for (int c = 0; c < 14; c++) tick(1'b1, 1'b0, '0);
    first_v = -1;
    for (int i = 0; i < vlog.size(); i++)
      if (first_v < 0 && vlog[i]) first_v = i + 1;
`ifdef FETCH_BYPASS_EN
    n_checks++;
    if (first_v != 1)
      $display("FAIL zw_first_valid got=%0d want=1", first_v);
    else n_pass++;
`else
    n_checks++;
    if (first_v != 2)
      $display("FAIL zw_first_valid got=%0d want=2", first_v);
    else n_pass++;
`endif
    nv = 0;
    for (int i = 2; i < 12; i++) if (vlog[i]) nv++;
    n_checks++;
    if (nv != 10)
      $display("FAIL zw_throughput got=%0d want=10", nv);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (issue_q[i] !== 32'(4 * i))
        $display("FAIL zw_addr[%0d] got=%h want=%h",
                 i, issue_q[i], 32'(4 * i));
      else n_pass++;
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL zw_data[%0d] got=%h want=%h",
                 i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (proto_err != 0)
      $display("FAIL zw_protocol got=%0d want=0", proto_err);
    else n_pass++;
  endtask

  task automatic test_fill_stall();
    wmin = 0; wmax = 0;
    do_reset();
    for (int c = 0; c < 10; c++) tick(1'b0, 1'b0, '0);
    n_checks++;
    if (issue_q.size() != DEPTH)
      $display("FAIL fill_count got=%0d want=%0d",
               issue_q.size(), DEPTH);
    else n_pass++;
    n_checks++;
    if (rlog[9] !== 1'b0)
      $display("FAIL fill_req_idle got=%b want=0", rlog[9]);
    else n_pass++;
    for (int c = 0; c < 12; c++) tick(1'b1, 1'b0, '0);
    n_checks++;
    if (got_q.size() < 8)
      $display("FAIL fill_progress got=%0d want>=8", got_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL fill_data[%0d] got=%h want=%h",
                 i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (issue_q[DEPTH] !== 32'h10)
      $display("FAIL fill_resume got=%h want=00000010",
               issue_q[DEPTH]);
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    wmin = 3; wmax = 3;
    do_reset();
    for (int c = 1; c <= 24; c++)
      tick(1'b1, c == 2, 32'h203);
    n_checks++;
    if (rlog[2] !== 1'b1 || alog[2] !== 32'h0
        || rlog[3] !== 1'b1 || alog[3] !== 32'h0)
      $display("FAIL rw_hold got=%b/%h %b/%h want=1/0 1/0",
               rlog[2], alog[2], rlog[3], alog[3]);
    else n_pass++;
    n_checks++;
    if (issue_q[1] !== 32'h200)
      $display("FAIL rw_target got=%h want=00000200", issue_q[1]);
    else n_pass++;
    n_checks++;
    if (got_q.size() < 3)
      $display("FAIL rw_progress got=%0d want>=3", got_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL rw_data[%0d] got=%h want=%h",
                 i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (proto_err != 0)
      $display("FAIL rw_protocol got=%0d want=0", proto_err);
    else n_pass++;
  endtask

  task automatic test_redirect_ack();
    wmin = 0; wmax = 0;
    do_reset();
    for (int c = 1; c <= 14; c++)
      tick(1'b1, c == 3, 32'h1000);
    n_checks++;
    if (vlog[3] !== 1'b0)
      $display("FAIL ra_valid_after got=%b want=0", vlog[3]);
    else n_pass++;
    n_checks++;
    if (issue_q[3] !== 32'h1000)
      $display("FAIL ra_target got=%h want=00001000", issue_q[3]);
    else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL ra_data[%0d] got=%h want=%h",
                 i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    wmin = 0; wmax = 0;
    do_reset();
    for (int c = 1; c <= 12; c++)
      tick(1'b1, c == 2, 32'hFFFF_FFFE);
    n_checks++;
    if (issue_q[2] !== 32'hFFFF_FFFC || issue_q[3] !== 32'h0)
      $display("FAIL wrap_addr got=%h,%h want=fffffffc,00000000",
               issue_q[2], issue_q[3]);
    else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL wrap_data[%0d] got=%h want=%h",
                 i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    wmin = 0; wmax = 0;
    do_reset();
    for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, '0);
    n_checks++;
    if (mem_req !== 1'b1 || instruction_valid !== 1'b1)
      $display("FAIL rm_pre got=%b%b want=11",
               mem_req, instruction_valid);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || instruction_valid !== 1'b0)
      $display("FAIL rm_async got=%b%b want=00",
               mem_req, instruction_valid);
    else n_pass++;
    n_checks++;
    if (mem_addr !== RESET_PC)
      $display("FAIL rm_addr got=%h want=%h", mem_addr, RESET_PC);
    else n_pass++;
    do_reset();
    for (int c = 0; c < 10; c++) tick(1'b1, 1'b0, '0);
    n_checks++;
    if (issue_q[0] !== RESET_PC)
      $display("FAIL rm_restart got=%h want=%h",
               issue_q[0], RESET_PC);
    else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL rm_data[%0d] got=%h want=%h",
                 i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int bad;
    for (int seg = 0; seg < 3; seg++) begin
      wmin = 0;
      wmax = seg;
      do_reset();
      for (int c = 0; c < 700; c++)
        tick($urandom_range(99, 0) < 75,
             $urandom_range(99, 0) < 3, $urandom);
      n_checks++;
      if (got_q.size() < 100)
        $display("FAIL rnd_progress seg=%0d got=%0d want>=100",
                 seg, got_q.size());
      else n_pass++;
      bad = 0;
      for (int i = 0; i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          bad++;
          if (bad <= 5)
            $display("FAIL rnd_data seg=%0d [%0d] got=%h want=%h",
                     seg, i, got_q[i], exp_q[i]);
        end else n_pass++;
      end
      n_checks++;
      if (proto_err != 0)
        $display("FAIL rnd_protocol seg=%0d got=%0d want=0",
                 seg, proto_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_fill_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
